// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use interlock and load-latency freeze for an in-order pipeline.
// Forwarding paths are purely combinational; only the wait FSM and the stall statistic are registered.
module hazard_forward_unit #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 4,
    parameter int                NPORT      = 3,
    parameter int                MEM_LAT    = 1,
    parameter logic [ADDR_W-1:0] NOFWD_ADDR = '1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORT-1:0]          id_rd_en,
    input  logic [NPORT*ADDR_W-1:0]   id_rd_addr,
    input  logic [NPORT*DATA_W-1:0]   id_rf_data,
    input  logic                      ex_wr_en,
    input  logic                      ex_is_load,
    input  logic [ADDR_W-1:0]         ex_wr_addr,
    input  logic [DATA_W-1:0]         ex_data,
    input  logic                      mw_wr_en,
    input  logic [ADDR_W-1:0]         mw_wr_addr,
    input  logic [DATA_W-1:0]         mw_data,
    input  logic                      stat_clr,
    output logic [NPORT*DATA_W-1:0]   fwd_data,
    output logic [NPORT-1:0]          fwd_hit,
    output logic                      stall_id,
    output logic                      mem_stall,
    output logic [15:0]               stall_cnt
);

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic {
        S_IDLE,
        S_LOAD_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_next_wait_cnt;
    logic [15:0] r_stall_cnt;
    logic [NPORT-1:0] w_load_use;
    logic        w_stall_any;

    // A load in EX cannot supply its value yet: the port falls through to
    // MEM/WB or the register file and the interlock raises a bubble instead.
    for (genvar g = 0; g < NPORT; g++) begin : g_port
        logic [ADDR_W-1:0] w_addr;
        logic              w_match_ex;
        logic              w_match_mw;

        assign w_addr     = id_rd_addr[g*ADDR_W +: ADDR_W];
        assign w_match_ex = id_rd_en[g] & ex_wr_en & (w_addr == ex_wr_addr) & (w_addr != NOFWD_ADDR);
        assign w_match_mw = id_rd_en[g] & mw_wr_en & (w_addr == mw_wr_addr) & (w_addr != NOFWD_ADDR);

        assign fwd_data[g*DATA_W +: DATA_W] = (w_match_ex & ~ex_is_load) ? ex_data :
                                              w_match_mw                 ? mw_data :
                                              id_rf_data[g*DATA_W +: DATA_W];
        assign fwd_hit[g]    = (w_match_ex & ~ex_is_load) | w_match_mw;
        assign w_load_use[g] = w_match_ex & ex_is_load;
    end

    assign mem_stall   = (r_state == S_LOAD_WAIT);
    assign stall_id    = (|w_load_use) & ~mem_stall;
    assign w_stall_any = stall_id | mem_stall;
    assign stall_cnt   = r_stall_cnt;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                if (ex_wr_en && ex_is_load && (LAT != 4'd0)) begin
                    w_next_state    = S_LOAD_WAIT;
                    w_next_wait_cnt = LAT;
                end
            end
            S_LOAD_WAIT: begin
                if (r_wait_cnt == 4'd1) begin
                    w_next_state    = S_IDLE;
                    w_next_wait_cnt = 4'd0;
                end else begin
                    w_next_wait_cnt = r_wait_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state    = S_IDLE;
                w_next_wait_cnt = 4'd0;
            end
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 16'd0;
        end else if (stat_clr) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall_any && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hazard_forward_unit;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NP    = 3;
    localparam int LAT   = 2;
    localparam logic [AW-1:0] NOFWD = 4'hF;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NP-1:0]     id_rd_en = '0;
    logic [NP*AW-1:0]  id_rd_addr = '0;
    logic [NP*DW-1:0]  id_rf_data = '0;
    logic              ex_wr_en = 1'b0;
    logic              ex_is_load = 1'b0;
    logic [AW-1:0]     ex_wr_addr = '0;
    logic [DW-1:0]     ex_data = '0;
    logic              mw_wr_en = 1'b0;
    logic [AW-1:0]     mw_wr_addr = '0;
    logic [DW-1:0]     mw_data = '0;
    logic              stat_clr = 1'b0;
    logic [NP*DW-1:0]  fwd_data;
    logic [NP-1:0]     fwd_hit;
    logic              stall_id;
    logic              mem_stall;
    logic [15:0]       stall_cnt;

    int total = 0;
    int bad   = 0;

    // Model state: remaining freeze cycles and the stall statistic.
    int m_wait = 0;
    int m_cnt  = 0;

    hazard_forward_unit #(
        .DATA_W(DW), .ADDR_W(AW), .NPORT(NP), .MEM_LAT(LAT), .NOFWD_ADDR(NOFWD)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rd_en(id_rd_en), .id_rd_addr(id_rd_addr), .id_rf_data(id_rf_data),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_data(ex_data),
        .mw_wr_en(mw_wr_en), .mw_wr_addr(mw_wr_addr), .mw_data(mw_data),
        .stat_clr(stat_clr),
        .fwd_data(fwd_data), .fwd_hit(fwd_hit), .stall_id(stall_id),
        .mem_stall(mem_stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Does port p need a value that is still being loaded?
    function automatic bit port_load_use(int p);
        logic [AW-1:0] a = id_rd_addr[p*AW +: AW];
        return id_rd_en[p] && ex_wr_en && ex_is_load && a == ex_wr_addr && a != NOFWD;
    endfunction

    function automatic bit any_load_use();
        bit r = 0;
        for (int p = 0; p < NP; p++) r = r | port_load_use(p);
        return r;
    endfunction

    // Youngest producer wins; a load in EX is skipped as a source.
    function automatic logic [DW:0] port_expect(int p);
        logic [AW-1:0] a = id_rd_addr[p*AW +: AW];
        if (id_rd_en[p] && a != NOFWD) begin
            if (ex_wr_en && !ex_is_load && a == ex_wr_addr) return {1'b1, ex_data};
            if (mw_wr_en && a == mw_wr_addr) return {1'b1, mw_data};
        end
        return {1'b0, id_rf_data[p*DW +: DW]};
    endfunction

    function automatic bit exp_stall_id();
        return any_load_use() && (m_wait == 0);
    endfunction

    function automatic bit exp_mem_stall();
        return m_wait > 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_wait = 0;
            m_cnt  = 0;
        end else begin
            if (stat_clr) m_cnt = 0;
            else if ((exp_stall_id() || exp_mem_stall()) && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_wait > 0) m_wait = m_wait - 1;
            else if (ex_wr_en && ex_is_load) m_wait = LAT;
        end
    end

    always @(negedge clk) begin
        logic [DW:0] e;
        for (int p = 0; p < NP; p++) begin
            e = port_expect(p);
            check($sformatf("fwd_data[%0d]", p), 32'(fwd_data[p*DW +: DW]), 32'(e[DW-1:0]));
            check($sformatf("fwd_hit[%0d]", p), 32'(fwd_hit[p]), 32'(e[DW]));
        end
        check("stall_id", 32'(stall_id), 32'(exp_stall_id()));
        check("mem_stall", 32'(mem_stall), 32'(exp_mem_stall()));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end

    task automatic quiet();
        id_rd_en = '0; ex_wr_en = 0; ex_is_load = 0; mw_wr_en = 0; stat_clr = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(int p, logic [AW-1:0] a, logic [DW-1:0] rf);
        id_rd_en[p] = 1'b1;
        id_rd_addr[p*AW +: AW] = a;
        id_rf_data[p*DW +: DW] = rf;
    endtask

    initial begin
        int guard;
        id_rf_data = {16'hC0C2, 16'hC0C1, 16'hC0C0};
        #12;
        check("reset stall_cnt", 32'(stall_cnt), 32'h0);
        check("reset mem_stall", 32'(mem_stall), 32'h0);
        // Forwarding and interlock must still work during reset.
        set_port(0, 4'd6, 16'h0006);
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 4'd6;
        #1;
        check("reset stall_id", 32'(stall_id), 32'h1);
        check("reset hit", 32'(fwd_hit[0]), 32'h0);
        quiet();
        #10 rst = 1'b1;

        // EX forwards a non-load result.
        next_cycle();
        set_port(0, 4'd3, 16'h0BAD);
        ex_wr_en = 1; ex_wr_addr = 4'd3; ex_data = 16'h1234;
        #1;
        check("ex fwd data", 32'(fwd_data[15:0]), 32'h1234);
        check("ex fwd hit", 32'(fwd_hit[0]), 32'h1);
        check("ex fwd stall", 32'(stall_id), 32'h0);

        // EX beats MW on the same address; MW takes over once EX drops.
        next_cycle();
        quiet();
        set_port(1, 4'd3, 16'h0BAD);
        ex_wr_en = 1; ex_wr_addr = 4'd3; ex_data = 16'hAAAA;
        mw_wr_en = 1; mw_wr_addr = 4'd3; mw_data = 16'h5555;
        #1;
        check("ex priority", 32'(fwd_data[31:16]), 32'hAAAA);
        next_cycle();
        ex_wr_en = 0;
        #1;
        check("mw fwd", 32'(fwd_data[31:16]), 32'h5555);

        // Load-use on two ports: one bubble, then LAT freeze cycles.
        next_cycle();
        quiet();
        stat_clr = 1;
        next_cycle();
        stat_clr = 0;
        set_port(0, 4'd5, 16'h0500);
        set_port(2, 4'd5, 16'h0502);
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 4'd5;
        #1;
        check("load-use stall_id", 32'(stall_id), 32'h1);
        check("load-use port0 rf", 32'(fwd_data[15:0]), 32'h0500);
        check("load-use no hit", 32'(fwd_hit), 32'h0);
        next_cycle();
        ex_wr_en = 0; ex_is_load = 0;
        #1;
        check("wait1 mem_stall", 32'(mem_stall), 32'h1);
        next_cycle();
        #1;
        check("wait2 mem_stall", 32'(mem_stall), 32'h1);
        next_cycle();
        #1;
        check("wait end mem_stall", 32'(mem_stall), 32'h0);
        check("load-use stall_cnt", 32'(stall_cnt), 32'd3);

        // The never-forwarded address goes straight to the register file.
        next_cycle();
        quiet();
        set_port(1, NOFWD, 16'h7E7E);
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = NOFWD;
        mw_wr_en = 1; mw_wr_addr = NOFWD; mw_data = 16'h1111;
        #1;
        check("nofwd data", 32'(fwd_data[31:16]), 32'h7E7E);
        check("nofwd hit", 32'(fwd_hit[1]), 32'h0);
        check("nofwd stall", 32'(stall_id), 32'h0);
        next_cycle();
        quiet();
        repeat (4) next_cycle();

        // Reset in the first freeze cycle aborts the wait at once.
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 4'd2;
        next_cycle();
        quiet();
        #1;
        check("pre-reset mem_stall", 32'(mem_stall), 32'h1);
        rst = 0;
        #1;
        check("abort mem_stall", 32'(mem_stall), 32'h0);
        check("abort stall_cnt", 32'(stall_cnt), 32'h0);
        rst = 1;

        // Saturation: keep a load-use pending so every cycle is a stall cycle.
        next_cycle();
        set_port(0, 4'd5, 16'h0);
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 4'd5;
        guard = 0;
        while (m_cnt < 16'hFFFE && guard < 70000) begin
            next_cycle();
            guard++;
        end
        if (guard >= 70000) check("saturation preload timeout", 32'(guard), 32'h0);
        repeat (3) next_cycle();
        check("saturated", 32'(stall_cnt), 32'hFFFF);
        stat_clr = 1;
        next_cycle();
        check("clear wins", 32'(stall_cnt), 32'h0);
        quiet();

        // Randomized traffic over a small address set to force frequent matches.
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            for (int p = 0; p < NP; p++) begin
                id_rd_en[p] = 1'($urandom_range(0, 3) != 0);
                id_rd_addr[p*AW +: AW] = ($urandom_range(0, 7) == 0) ? NOFWD : 4'($urandom_range(0, 3));
                id_rf_data[p*DW +: DW] = 16'($urandom);
            end
            ex_wr_en   = 1'($urandom_range(0, 1));
            ex_is_load = 1'($urandom_range(0, 3) == 0);
            ex_wr_addr = ($urandom_range(0, 7) == 0) ? NOFWD : 4'($urandom_range(0, 3));
            ex_data    = 16'($urandom);
            mw_wr_en   = 1'($urandom_range(0, 1));
            mw_wr_addr = ($urandom_range(0, 7) == 0) ? NOFWD : 4'($urandom_range(0, 3));
            mw_data    = 16'($urandom);
            stat_clr   = 1'($urandom_range(0, 31) == 0);
            rst        = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
        end
        next_cycle();
        rst = 1;
        quiet();
        repeat (2) next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
